// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin ALU/MEM write-port sharing plus
// per-register pending-write scoreboard. Optional forwarding via `WB_BYPASS_EN.
module regfile_wb_arbiter #(
   parameter int BIT_WIDTH = 32,
   parameter int REG_WIDTH = 4,
   parameter int CNT_WIDTH = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 issueEn,
   input  logic [REG_WIDTH-1:0] issueDr,
   output logic                 issueReady,
   input  logic                 aluValid,
   input  logic [REG_WIDTH-1:0] aluDr,
   input  logic [BIT_WIDTH-1:0] aluData,
   output logic                 aluReady,
   input  logic                 memValid,
   input  logic [REG_WIDTH-1:0] memDr,
   input  logic [BIT_WIDTH-1:0] memData,
   output logic                 memReady,
   output logic                 wrtEn,
   output logic [REG_WIDTH-1:0] dr,
   output logic [BIT_WIDTH-1:0] dIn,
   input  logic [REG_WIDTH-1:0] sr1,
   input  logic [REG_WIDTH-1:0] sr2,
   output logic                 hazard,
   output logic                 errSticky
`ifdef WB_BYPASS_EN
   ,
   output logic                 sr1Fwd,
   output logic                 sr2Fwd,
   output logic [BIT_WIDTH-1:0] fwdData
`endif
);

   localparam int REG_SIZE = 1 << REG_WIDTH;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [CNT_WIDTH-1:0] count_q [REG_SIZE];
   logic [CNT_WIDTH-1:0] count_d [REG_SIZE];
   logic [REG_SIZE-1:0]  inc_vec;
   logic [REG_SIZE-1:0]  dec_vec;
   logic                 rr_ptr_q, rr_ptr_d;
   logic                 err_q, err_d;
   logic                 alu_gnt, mem_gnt, issue_acc;

   // Grants are forced low while reset is asserted so the write port is quiet.
   assign alu_gnt = !reset && aluValid && (!memValid || !rr_ptr_q);
   assign mem_gnt = !reset && memValid && (!aluValid ||  rr_ptr_q);

   assign aluReady = alu_gnt;
   assign memReady = mem_gnt;
   assign wrtEn    = alu_gnt | mem_gnt;
   assign dr       = alu_gnt ? aluDr   : (mem_gnt ? memDr   : '0);
   assign dIn      = alu_gnt ? aluData : (mem_gnt ? memData : '0);

   assign issueReady = (count_q[issueDr] != CNT_MAX);
   assign issue_acc  = issueEn && issueReady;
   assign errSticky  = err_q;

   generate
      for (genvar gi = 0; gi < REG_SIZE; gi++) begin : g_sb
         assign inc_vec[gi] = issue_acc && (issueDr == REG_WIDTH'(gi));
         assign dec_vec[gi] = wrtEn && (dr == REG_WIDTH'(gi));
      end
   endgenerate

   always_comb begin
      for (int i = 0; i < REG_SIZE; i++) begin
         count_d[i] = count_q[i];
         if (inc_vec[i] && !dec_vec[i]) begin
            count_d[i] = count_q[i] + 1'b1;
         end else if (dec_vec[i] && !inc_vec[i] && (count_q[i] != '0)) begin
            count_d[i] = count_q[i] - 1'b1;
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      // Only contested cycles move the pointer, and it moves to the loser.
      if (aluValid && memValid) begin
         rr_ptr_d = alu_gnt;
      end
      err_d = err_q | (wrtEn && (count_q[dr] == '0));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < REG_SIZE; i++) begin
            count_q[i] <= '0;
         end
         rr_ptr_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         for (int i = 0; i < REG_SIZE; i++) begin
            count_q[i] <= count_d[i];
         end
         rr_ptr_q <= rr_ptr_d;
         err_q    <= err_d;
      end
   end

`ifdef WB_BYPASS_EN
   // A source is forwardable when the write being granted retires its last pending write.
   assign sr1Fwd  = wrtEn && (dr == sr1) && (count_q[sr1] == CNT_WIDTH'(1));
   assign sr2Fwd  = wrtEn && (dr == sr2) && (count_q[sr2] == CNT_WIDTH'(1));
   assign fwdData = dIn;
   assign hazard  = ((count_q[sr1] != '0) && !sr1Fwd) || ((count_q[sr2] != '0) && !sr2Fwd);
`else
   assign hazard  = (count_q[sr1] != '0) || (count_q[sr2] != '0);
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios then randomized
// traffic compared against a counter/round-robin reference model.
module tb_regfile_wb_arbiter;
   localparam int BW = 32;
   localparam int RW = 4;
   localparam int MAXC = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          issueEn, aluValid, memValid;
   logic [RW-1:0] issueDr, aluDr, memDr, sr1, sr2;
   logic [BW-1:0] aluData, memData;
   logic          issueReady, aluReady, memReady, wrtEn, hazard, errSticky;
   logic [RW-1:0] dr;
   logic [BW-1:0] dIn;
`ifdef WB_BYPASS_EN
   logic          sr1Fwd, sr2Fwd;
   logic [BW-1:0] fwdData;
`endif

   regfile_wb_arbiter #(.BIT_WIDTH(BW), .REG_WIDTH(RW), .CNT_WIDTH(2)) dut (
      .clk(clk), .reset(reset),
      .issueEn(issueEn), .issueDr(issueDr), .issueReady(issueReady),
      .aluValid(aluValid), .aluDr(aluDr), .aluData(aluData), .aluReady(aluReady),
      .memValid(memValid), .memDr(memDr), .memData(memData), .memReady(memReady),
      .wrtEn(wrtEn), .dr(dr), .dIn(dIn), .sr1(sr1), .sr2(sr2),
      .hazard(hazard), .errSticky(errSticky)
`ifdef WB_BYPASS_EN
      , .sr1Fwd(sr1Fwd), .sr2Fwd(sr2Fwd), .fwdData(fwdData)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_cnt [16];
   bit m_rr;
   bit m_err;

   // Outputs seen in the most recent cycle
   logic o_alu, o_mem, o_we, o_haz, o_irdy, o_err;
   logic [RW-1:0] o_dr;
   logic [BW-1:0] o_din;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_cnt[i] = 0;
      m_rr  = 1'b0;
      m_err = 1'b0;
   endtask

   task automatic idle_inputs();
      issueEn = 0; issueDr = 0; aluValid = 0; aluDr = 0; aluData = 0;
      memValid = 0; memDr = 0; memData = 0; sr1 = 0; sr2 = 0;
   endtask

   // Inputs are set by the caller just after a posedge; this checks mid-cycle and advances one clock.
   task automatic cycle(input string tag);
      bit ga, gm, we, irdy, haz, f1, f2;
      int edr;
      logic [BW-1:0] edin;
      @(negedge clk);
      #1;
      ga   = aluValid && (!memValid || !m_rr);
      gm   = memValid && (!aluValid || m_rr);
      we   = ga || gm;
      edr  = ga ? int'(aluDr) : (gm ? int'(memDr) : 0);
      edin = ga ? aluData : (gm ? memData : '0);
      irdy = m_cnt[issueDr] < MAXC;
      f1 = 0; f2 = 0;
`ifdef WB_BYPASS_EN
      f1 = we && (edr == int'(sr1)) && (m_cnt[sr1] == 1);
      f2 = we && (edr == int'(sr2)) && (m_cnt[sr2] == 1);
      check({tag, ".sr1Fwd"}, 64'(sr1Fwd), 64'(f1));
      check({tag, ".sr2Fwd"}, 64'(sr2Fwd), 64'(f2));
      check({tag, ".fwdData"}, 64'(fwdData), 64'(edin));
`endif
      haz = (m_cnt[sr1] != 0 && !f1) || (m_cnt[sr2] != 0 && !f2);
      o_alu = aluReady; o_mem = memReady; o_we = wrtEn; o_dr = dr; o_din = dIn;
      o_haz = hazard; o_irdy = issueReady; o_err = errSticky;
      check({tag, ".aluReady"},   64'(aluReady),   64'(ga));
      check({tag, ".memReady"},   64'(memReady),   64'(gm));
      check({tag, ".wrtEn"},      64'(wrtEn),      64'(we));
      check({tag, ".dr"},         64'(dr),         64'(edr));
      check({tag, ".dIn"},        64'(dIn),        64'(edin));
      check({tag, ".hazard"},     64'(hazard),     64'(haz));
      check({tag, ".issueReady"}, 64'(issueReady), 64'(irdy));
      check({tag, ".errSticky"},  64'(errSticky),  64'(m_err));
      if (we && m_cnt[edr] == 0) m_err = 1;
      if (issueEn && irdy && we && int'(issueDr) == edr) begin
         // reserve and retire of the same register cancel out
      end else begin
         if (issueEn && irdy) m_cnt[issueDr]++;
         if (we && m_cnt[edr] > 0) m_cnt[edr]--;
      end
      if (aluValid && memValid) m_rr = ga;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit alu_seq [3];
      idle_inputs();
      reset = 1;
      model_reset();
      #1;
      aluValid = 1; memValid = 1; aluDr = 4; memDr = 6;
      #1;
      check("rst.aluReady",   64'(aluReady),   64'(0));
      check("rst.memReady",   64'(memReady),   64'(0));
      check("rst.wrtEn",      64'(wrtEn),      64'(0));
      check("rst.hazard",     64'(hazard),     64'(0));
      check("rst.issueReady", 64'(issueReady), 64'(1));
      check("rst.errSticky",  64'(errSticky),  64'(0));
      idle_inputs();
      @(posedge clk); @(posedge clk); #1;
      reset = 0;

      // Issue r3, observe hazard, ALU writes it back
      issueEn = 1; issueDr = 3; sr1 = 3;
      cycle("iss3");
      issueEn = 0;
      cycle("haz3");
      check("haz3.explicit", 64'(o_haz), 64'(1));
      aluValid = 1; aluDr = 3; aluData = 32'hDEADBEEF;
      cycle("wr3");
      check("wr3.wrtEn", 64'(o_we),  64'(1));
      check("wr3.dr",    64'(o_dr),  64'(3));
      check("wr3.dIn",   64'(o_din), 64'(32'hDEADBEEF));
      aluValid = 0;
      cycle("post3");
      check("post3.hazard", 64'(o_haz), 64'(0));

      // Contention: reserve r1 twice and r2 once, then both requesters valid for 3 cycles
      sr1 = 0;
      issueEn = 1; issueDr = 1; cycle("res1a"); cycle("res1b");
      issueDr = 2; cycle("res2");
      issueEn = 0;
      aluValid = 1; aluDr = 1; aluData = 32'h1111; memValid = 1; memDr = 2; memData = 32'h2222;
      for (int k = 0; k < 3; k++) begin
         cycle("rr");
         alu_seq[k] = o_alu;
         check("rr.wrtEn", 64'(o_we), 64'(1));
      end
      check("rr.grant0", 64'(alu_seq[0]), 64'(1));
      check("rr.grant1", 64'(alu_seq[1]), 64'(0));
      check("rr.grant2", 64'(alu_seq[2]), 64'(1));
      aluValid = 0; memValid = 0;
      cycle("rr.idle");

      // Saturate r5
      issueEn = 1; issueDr = 5;
      for (int k = 0; k < 3; k++) cycle("sat5");
      issueEn = 0;
      cycle("full5");
      check("full5.issueReady", 64'(o_irdy), 64'(0));
      memValid = 1; memDr = 5; memData = 32'h55;
      cycle("wr5");
      memValid = 0;
      cycle("free5");
      check("free5.issueReady", 64'(o_irdy), 64'(1));

      // Same-cycle issue and writeback of r7
      issueEn = 1; issueDr = 7; cycle("res7");
      memValid = 1; memDr = 7; memData = 32'h77; sr2 = 7;
      cycle("same7");
      issueEn = 0; memValid = 0;
      cycle("hold7");
      check("hold7.hazard",    64'(o_haz), 64'(1));
      check("hold7.errSticky", 64'(o_err), 64'(0));

      // Write to an unreserved register
      sr2 = 0;
      memValid = 1; memDr = 9; memData = 32'h99;
      cycle("err9");
      check("err9.wrtEn", 64'(o_we), 64'(1));
      check("err9.dr",    64'(o_dr), 64'(9));
      memValid = 0;
      for (int k = 0; k < 3; k++) begin
         cycle("err9.hold");
         check("err9.sticky", 64'(o_err), 64'(1));
      end

      // Reset in the middle of contention
      aluValid = 1; aluDr = 7; aluData = 32'hA; memValid = 1; memDr = 5; memData = 32'hB;
      cycle("mid.c0");
      @(negedge clk); #1;
      check("mid.memReady.pre", 64'(memReady), 64'(!m_rr ? 0 : 1));
      reset = 1;
      #1;
      check("mid.aluReady", 64'(aluReady), 64'(0));
      check("mid.memReady", 64'(memReady), 64'(0));
      check("mid.wrtEn",    64'(wrtEn),    64'(0));
      check("mid.hazard",   64'(hazard),   64'(0));
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      reset = 0;
      cycle("mid.after");
      check("mid.after.alu",   64'(o_alu), 64'(1));
      check("mid.after.err",   64'(o_err), 64'(0));
      aluValid = 0; memValid = 0;
      cycle("mid.idle");

      // Randomized traffic; a requester that was not granted keeps its request
      for (int n = 0; n < 400; n++) begin
         issueEn = 1'($urandom_range(0, 1));
         issueDr = RW'($urandom_range(0, 7));
         sr1 = RW'($urandom_range(0, 7));
         sr2 = RW'($urandom_range(0, 7));
         if (!(aluValid && !o_alu)) begin
            aluValid = ($urandom_range(0, 2) != 0);
            aluDr    = RW'($urandom_range(0, 7));
            aluData  = $urandom;
         end
         if (!(memValid && !o_mem)) begin
            memValid = ($urandom_range(0, 2) != 0);
            memDr    = RW'($urandom_range(0, 7));
            memData  = $urandom;
         end
         cycle("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (wrtEn/dr/dIn) between two writeback requesters: ALU result and memory/load result.
- Keeps a per-register pending-write scoreboard so decode can stall on read-after-write hazards.
- Sits between the execute/memory stages and the register file in the 2-stage pipeline.

Parameters:
BIT_WIDTH, 32, data width of register values
REG_WIDTH, 4, register index width; REG_SIZE = 1 << REG_WIDTH registers
CNT_WIDTH, 2, width of per-register pending-write counter; max count = 2^CNT_WIDTH - 1

Ports:
clk  input  1  single clock, all state updates on posedge
reset  input  1  asynchronous, active-high reset
issueEn  input  1  decode issues an instruction that will write issueDr
issueDr  input  REG_WIDTH  destination register being reserved
issueReady  output  1  high when count[issueDr] < max; issue accepted only when issueEn && issueReady
aluValid  input  1  ALU writeback request
aluDr  input  REG_WIDTH  ALU destination
aluData  input  BIT_WIDTH  ALU result
aluReady  output  1  ALU request granted this cycle
memValid  input  1  memory writeback request
memDr  input  REG_WIDTH  memory destination
memData  input  BIT_WIDTH  load result
memReady  output  1  memory request granted this cycle
wrtEn  output  1  register-file write enable
dr  output  REG_WIDTH  register-file write index
dIn  output  BIT_WIDTH  register-file write data
sr1, sr2  input  REG_WIDTH  decode source registers
hazard  output  1  count[sr1] != 0 or count[sr2] != 0
errSticky  output  1  set when a write targets a register whose count is 0; cleared only by reset

Behaviour:
- Write port is combinational from the grant: wrtEn = aluReady | memReady; dr/dIn mux from the winner; dr = 0 and dIn = 0 when idle.
- Grant rules: only one valid -> grant it; both valid -> grant the side selected by rrPtr (0 = ALU, 1 = MEM); neither -> no grant. At most one of aluReady/memReady is high per cycle.
- rrPtr (1 bit) updates only on a contested cycle (both valid): it points to the loser for the next cycle. Uncontested grants leave rrPtr unchanged.
- A non-granted requester must hold valid/dr/data stable until granted.
- Scoreboard: count[i] increments on an accepted issue to i and decrements on a granted write to i.
- Same-cycle issue and write to the same register: count unchanged.
- Issue to a register at max count: issueReady = 0, no increment.
- Granted write with count 0: write still performed, count stays 0, errSticky set on the next edge.
- hazard is combinational from the current counts (no same-cycle bypass of a write being granted).
- Reset (async, any time, including mid-contention): all counts 0, rrPtr = 0, errSticky = 0. During reset, aluReady = memReady = wrtEn = 0 and hazard = 0. issueReady is high after reset.

Optional Feature:
WB_BYPASS_EN
- When defined:
  - Adds outputs sr1Fwd and sr2Fwd (1 bit each) and fwdData (BIT_WIDTH).
  - srNFwd is high when wrtEn and dr == srN and count[srN] == 1; fwdData = dIn.
  - hazard excludes any source covered by forwarding.
- When undefined: these ports are absent and hazard is as above.

Test Plan:
- Reset then issue r3 (issueEn=1, issueDr=3) -> next cycle count[3]=1; with sr1=3, hazard=1; ALU write r3=0xDEADBEEF -> wrtEn=1, dr=3, dIn=0xDEADBEEF; hazard=0 the following cycle.
- aluValid and memValid both high for 3 cycles, reset rrPtr=0 -> grants ALU, MEM, ALU in order; wrtEn=1 each cycle.
- Issue r5 three times (CNT_WIDTH=2) -> issueReady=0 with issueDr=5; one r5 write -> issueReady=1 again.
- Same-cycle issue r7 and MEM write r7 while count[7]=1 -> count[7] stays 1; hazard on sr2=7 stays 1.
- MEM write to r9 with count[9]=0 -> wrtEn=1, dr=9; errSticky=1 next cycle and held until reset.
- Assert reset mid-contention (both valid) -> aluReady, memReady and wrtEn drop immediately; after release, rrPtr=0 and ALU wins first.
